// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: records control-flow discontinuities of a CPU program counter.
// Each cycle the incoming PC is compared with the previous PC + 4. When they differ
// while capture is running, the pair {from_pc, to_pc} is pushed into a
// first-word-fall-through FIFO. The consumer drains it through a valid/ready port.
// A small FSM (IDLE/RUN/FROZEN) gates capture. Overflow can either drop entries and
// keep running, or freeze capture at the first drop.
module pc_trace_buffer #(
  parameter int DEPTH        = 16,   // power of two, >= 2
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,       // asynchronous, active-low
  input  logic [31:0]              pc_in,
  input  logic                     arm,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [63:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  state_t          r_state;
  logic [31:0]     r_prev_pc;
  logic            r_have_prev;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [7:0]      r_drop_cnt;
  logic [63:0]     r_mem [DEPTH];

  logic [31:0]     w_seq_pc;
  logic            w_disc;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // The sequential successor wraps naturally at 2^32 because the sum is 32 bits wide.
  assign w_seq_pc = r_prev_pc + 32'd4;
  assign w_disc   = (r_state == S_RUN) && r_have_prev && (pc_in != w_seq_pc);

  // Full and empty come from the occupancy count, so the pointers never need an extra wrap bit.
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);

  // A pop frees a slot in the same cycle, so a jump arriving while full is still accepted.
  assign w_pop    = !w_empty && rd_ready;
  assign w_push   = w_disc && (!w_full || w_pop);
  assign w_drop   = w_disc && w_full && !w_pop;

  assign rd_valid = !w_empty;
  assign rd_data  = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign state    = r_state;

  // Capture FSM plus the sticky overflow flag and drop counter it clears on arm rise.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_have_prev <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      // have_prev goes high one edge after RUN is entered and is cleared by any IDLE cycle.
      r_have_prev <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state    <= S_RUN;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
          end
        end
        S_RUN: begin
          if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
          end
          if (!arm)                        r_state <= S_IDLE;
          else if (w_drop && STOP_ON_FULL) r_state <= S_FROZEN;
        end
        S_FROZEN: begin
          if (!arm) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Previous-PC register, sampled every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev_pc <= 32'd0;
    else      r_prev_pc <= pc_in;
  end

  // FIFO pointers and occupancy; reset discards every stored entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written with {from_pc, to_pc} on every accepted push.
  // NOTE: the array has no reset; empty slots are never observable because rd_valid derives from count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_prev_pc, pc_in};
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Testbench for pc_trace_buffer. Two DEPTH=4 instances share one stimulus stream:
// instance 0 keeps running on overflow, instance 1 freezes. A reference model
// predicts accepted entries into per-instance scoreboard queues, and a monitor
// compares the DUT's read port and status outputs against it on every falling edge.
module tb_pc_trace_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        rd_ready;
  logic [31:0] pc_in;

  logic        v0, v1;
  logic [63:0] d0, d1;
  logic [2:0]  c0, c1;
  logic        o0, o1;
  logic [7:0]  dc0, dc1;
  logic [1:0]  s0, s1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (state encoding: 0 idle, 1 run, 2 frozen).
  int          m_cnt   [2];
  int          m_state [2];
  bit          m_ovf   [2];
  int          m_drop  [2];
  bit          m_hp    [2];
  logic [31:0] m_prev;
  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];

  pc_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) u_run (
    .clk(clk), .rst(rst_n), .pc_in(pc_in), .arm(arm), .rd_ready(rd_ready),
    .rd_valid(v0), .rd_data(d0), .count(c0), .overflow(o0), .drop_cnt(dc0), .state(s0)
  );

  pc_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) u_stop (
    .clk(clk), .rst(rst_n), .pc_in(pc_in), .arm(arm), .rd_ready(rd_ready),
    .rd_valid(v1), .rd_data(d1), .count(c1), .overflow(o1), .drop_cnt(dc1), .state(s1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]   = 0;
      m_state[k] = 0;
      m_ovf[k]   = 1'b0;
      m_drop[k]  = 0;
      m_hp[k]    = 1'b0;
    end
    m_prev = 32'd0;
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  // Advances the model by one clock edge using the inputs the DUT just sampled.
  function automatic void model_update();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] seq_pc;
      bit          disc;
      bit          pop;
      bit          drop;
      seq_pc = m_prev + 32'd4;
      disc   = (m_state[k] == 1) && m_hp[k] && (pc_in != seq_pc);
      pop    = (m_cnt[k] > 0) && rd_ready;
      drop   = 1'b0;
      if (disc) begin
        if (m_cnt[k] < DEPTH || pop) begin
          if (k == 0) exp_q0.push_back({m_prev, pc_in});
          else        exp_q1.push_back({m_prev, pc_in});
          m_cnt[k]++;
        end else begin
          drop = 1'b1;
        end
      end
      if (pop) m_cnt[k]--;
      if (drop) begin
        m_ovf[k] = 1'b1;
        if (m_drop[k] < 255) m_drop[k]++;
      end
      m_hp[k] = (m_state[k] == 1);
      case (m_state[k])
        0: if (arm) begin
             m_state[k] = 1;
             m_ovf[k]   = 1'b0;
             m_drop[k]  = 0;
           end
        1: if (!arm)                  m_state[k] = 0;
           else if (drop && k == 1)   m_state[k] = 2;
        default: if (!arm) m_state[k] = 0;
      endcase
    end
    m_prev = pc_in;
  endfunction

  // Applies one cycle of inputs, lets the clock edge happen, then steps the model.
  task automatic step(input logic a, input logic r, input logic [31:0] p);
    arm      = a;
    rd_ready = r;
    pc_in    = p;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic mon_inst(input int k, input logic v, input logic [63:0] d, input logic [2:0] c,
                          input logic ovf, input logic [7:0] dc, input logic [1:0] st);
    logic [63:0] exp_d;
    int          qsize;
    check($sformatf("count%0d", k),    64'(c),   64'(m_cnt[k]));
    check($sformatf("rd_valid%0d", k), 64'(v),   64'(m_cnt[k] != 0));
    check($sformatf("state%0d", k),    64'(st),  64'(m_state[k]));
    check($sformatf("overflow%0d", k), 64'(ovf), 64'(m_ovf[k]));
    check($sformatf("drop_cnt%0d", k), 64'(dc),  64'(m_drop[k]));
    if (v && rd_ready) begin
      qsize = (k == 0) ? exp_q0.size() : exp_q1.size();
      if (qsize == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_pop%0d: got entry 0x%0h expected no entry at %0t", k, d, $time);
      end else begin
        exp_d = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("rd_data%0d", k), d, exp_d);
      end
    end
  endtask

  // Monitor: compares both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      mon_inst(0, v0, d0, c0, o0, dc0, s0);
      mon_inst(1, v1, d1, c1, o1, dc1, s1);
    end
  end

  logic [31:0] r_pc;
  logic        r_arm;

  initial begin
    rst_n    = 1'b1;
    arm      = 1'b0;
    rd_ready = 1'b0;
    pc_in    = 32'd0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("reset_count0", 64'(c0), 64'd0);
    check("reset_valid1", 64'(v1), 64'd0);
    check("reset_state0", 64'(s0), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Purely sequential PCs never produce an entry.
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd4);
    step(1'b1, 1'b0, 32'd8);
    step(1'b1, 1'b0, 32'd12);

    // One jump, then a single-cycle read.
    step(1'b1, 1'b0, 32'h10);
    step(1'b1, 1'b0, 32'h14);
    step(1'b1, 1'b0, 32'h40);
    #3;
    check("jump_entry", d0, 64'h00000014_00000040);
    check("jump_count", 64'(c0), 64'd1);
    #1;
    step(1'b1, 1'b1, 32'h44);
    step(1'b1, 1'b0, 32'h48);

    // Six jumps with no reads: instance 0 drops two, instance 1 freezes on the fifth.
    for (int j = 1; j <= 6; j++) step(1'b1, 1'b0, 32'h1000 * j);
    step(1'b1, 1'b0, 32'h6004);
    #3;
    check("ovf_drop_run",   64'(dc0), 64'd2);
    check("ovf_state_stop", 64'(s1),  64'd2);
    check("ovf_drop_stop",  64'(dc1), 64'd1);
    #1;

    // Disarm and re-arm: flags clear, stored entries survive.
    step(1'b0, 1'b0, 32'h7000);
    step(1'b1, 1'b0, 32'h7000);
    step(1'b1, 1'b0, 32'h7004);
    // Jump while full with a simultaneous read: both accept the new entry.
    step(1'b1, 1'b1, 32'hA000);
    step(1'b1, 1'b0, 32'hA004);

    // Drain everything while idle.
    for (int j = 0; j < 6; j++) step(1'b0, 1'b1, 32'hB000 + 32'(4 * j));

    // Address wrap is sequential; then a jump and an asynchronous reset between edges.
    step(1'b1, 1'b0, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0000_0000);
    step(1'b1, 1'b0, 32'h0000_2000);
    step(1'b1, 1'b0, 32'h0000_2004);
    #2 rst_n = 1'b0;
    model_reset();
    arm = 1'b0;
    #1;
    check("async_rst_valid0", 64'(v0), 64'd0);
    check("async_rst_count0", 64'(c0), 64'd0);
    check("async_rst_valid1", 64'(v1), 64'd0);
    check("async_rst_count1", 64'(c1), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic: mostly sequential PCs, frequent jumps, sparse reads, rare arm toggles.
    r_pc  = 32'h0000_8000;
    r_arm = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0 || i == 0) r_arm = ~r_arm;
      if ($urandom_range(0, 2) == 0) r_pc = $urandom() & 32'hFFFF_FFFC;
      else                           r_pc = r_pc + 32'd4;
      step(r_arm, ($urandom_range(0, 2) == 0), r_pc);
    end

    for (int j = 0; j < 8; j++) step(1'b0, 1'b1, 32'hC000 + 32'(4 * j));
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
